// File: rtl/mem_port_arbiter.sv
// Two-port sequencing arbiter in front of a single-port 16-bit memory macro.
// Fetch and data requests are serialised, padded with wait states, and completed with done pulses.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_done,
   output logic [15:0]           if_rdata,
   input  logic                  d_req,
   input  logic                  d_wr,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [15:0]           d_wdata,
   output logic                  d_gnt,
   output logic                  d_done,
   output logic [15:0]           d_rdata,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_wdata,
   output logic                  mem_enable,
   output logic                  mem_wr,
   input  logic [15:0]           mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

   localparam logic PortFetch = 1'b0;
   localparam logic PortData  = 1'b1;

   // Counter preload: WAIT cycles run while counting from WAIT_STATES-1 down to 0.
   localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  last_win_q, last_win_d;
   logic                  win_q, win_d;
   logic                  err_q, err_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           wdata_q, wdata_d;
   logic [15:0]           if_rdata_q, if_rdata_d;
   logic [15:0]           d_rdata_q, d_rdata_d;

   logic                  grant;
   logic                  pick_d;
   logic                  misalign;
   logic [ADDR_WIDTH-1:0] req_addr;

   // Arbitration: lone requester wins; on a tie the port not served last wins.
   always_comb begin
      pick_d   = d_req & (~if_req | (last_win_q == PortFetch));
      req_addr = pick_d ? d_addr : if_addr;
      grant    = (state_q == StIdle) & (if_req | d_req);
      misalign = req_addr[0];
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (grant) begin
               if (misalign) begin
                  state_d = StDone;
               end else if (WAIT_STATES == 0) begin
                  state_d = StAccess;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StAccess;
            end
         end
         StAccess: state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      if_gnt     = grant & (pick_d == PortFetch);
      d_gnt      = grant & (pick_d == PortData);
      if_done    = (state_q == StDone) & (win_q == PortFetch);
      d_done     = (state_q == StDone) & (win_q == PortData);
      err        = (state_q == StDone) & err_q;
      mem_enable = (state_q == StAccess);
      mem_wr     = (state_q == StAccess) & wr_q;
      busy       = (state_q != StIdle);
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      if_rdata   = if_rdata_q;
      d_rdata    = d_rdata_q;
   end

   // Datapath next-state: request latch at grant, read capture at the end of ACCESS.
   always_comb begin
      cnt_d      = cnt_q;
      last_win_d = last_win_q;
      win_d      = win_q;
      err_d      = err_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;

      if (grant) begin
         cnt_d      = WaitLoad;
         last_win_d = pick_d;
         win_d      = pick_d;
         err_d      = misalign;
         wr_d       = pick_d & d_wr;
         addr_d     = req_addr;
         if (pick_d) begin
            wdata_d = d_wdata;
         end
         // Misaligned: no access happens, so the winner's read data is cleared ahead of done.
         if (misalign) begin
            if (pick_d) begin
               d_rdata_d = 16'h0000;
            end else begin
               if_rdata_d = 16'h0000;
            end
         end
      end

      if ((state_q == StWait) && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end

      if ((state_q == StAccess) && !wr_q) begin
         if (win_q == PortData) begin
            d_rdata_d = mem_rdata;
         end else begin
            if_rdata_d = mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= 4'd0;
         last_win_q <= PortFetch;
         win_q      <= PortFetch;
         err_q      <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 16'h0000;
         if_rdata_q <= 16'h0000;
         d_rdata_q  <= 16'h0000;
      end else begin
         cnt_q      <= cnt_d;
         last_win_q <= last_win_d;
         win_q      <= win_d;
         err_q      <= err_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing arbiter that shares one single-port, 16-bit, byte-addressed memory between the instruction-fetch port and the data (load/store) port. It serialises accesses so read and write never occur in the same cycle. It inserts a programmable number of wait states to model slow memory, and returns read data and completion pulses to each requester. It sits between the fetch/memory pipeline stages and the memory macro, and drives the macro's addr/data_in/enable/wr and receives its data_out.

## Interface
- ADDR_WIDTH, 16, byte-address width shared by both ports and the memory.
- WAIT_STATES, 2, idle cycles between grant and memory access; legal range 0..15.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- if_req  input  1  fetch read request; held until if_gnt.
- if_addr  input  ADDR_WIDTH  fetch byte address; stable while if_req=1.
- if_gnt  output  1  fetch request accepted this cycle.
- if_done  output  1  one-cycle fetch completion pulse.
- if_rdata  output  16  fetch read data; valid with if_done and held until the next fetch completion.
- d_req  input  1  data request; held until d_gnt.
- d_wr  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_WIDTH  data byte address.
- d_wdata  input  16  write data.
- d_gnt  output  1  data request accepted this cycle.
- d_done  output  1  one-cycle data completion pulse.
- d_rdata  output  16  data read data; valid with d_done and held until the next data completion.
- err  output  1  qualifies the current if_done/d_done: misaligned address, no access performed.
- mem_addr  output  ADDR_WIDTH  memory address (latched request address).
- mem_wdata  output  16  memory write data.
- mem_enable  output  1  memory enable; high only in ACCESS.
- mem_wr  output  1  memory write strobe; high only in ACCESS for writes.
- mem_rdata  input  16  memory combinational read data.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE: if any req is high, choose a winner, assert its gnt combinationally, and latch addr, wdata, wr, and the winner id at the edge.
  - Next state is WAIT if WAIT_STATES>0, otherwise ACCESS.
  - If the latched addr[0]=1, next state is DONE with an error flag, and memory is never enabled.
- Arbitration: a single requester wins outright. If both are pending, the port not served last wins.
  - last_win resets to "fetch", so data wins the first tie.
  - last_win updates at every grant.
- WAIT: a 4-bit counter loads WAIT_STATES-1 at grant and decrements each cycle. ACCESS is entered when the counter reaches 0.
- ACCESS: exactly one cycle with mem_enable=1 and mem_wr = latched wr (always 0 for fetch).
  - Reads capture mem_rdata into the winner's rdata register at the ending edge.
  - Writes commit at the same edge.
- DONE: the winner's done pulses for one cycle, with err = error flag. On error, the winner's rdata is set to 0x0000. Next state is always IDLE.
- Requests arriving while busy wait; they are not granted until IDLE.
- Dropping req after gnt does not cancel the transaction.
- The non-winning port's rdata is untouched.
- When mem_enable=0: mem_wr=0, and mem_addr/mem_wdata show the latched values.

## Timing
- Grant in cycle 0. ACCESS in cycle WAIT_STATES+1. done in cycle WAIT_STATES+2. IDLE again in cycle WAIT_STATES+3.
- Throughput: one transaction per WAIT_STATES+3 cycles. A back-to-back pending request is granted in the IDLE cycle after DONE.
- Misaligned transaction: done/err in cycle 1, IDLE in cycle 2.
- Reset (rst=0, asynchronous): state=IDLE, counter=0, last_win=fetch, and the error flag cleared.
  - Outputs: all gnt/done/err/busy/mem_enable/mem_wr = 0; if_rdata, d_rdata, mem_addr, mem_wdata = 0.
  - An in-flight transaction is dropped with no done and no write.
  - Reset deasserting mid-cycle: the first grant can occur in the first IDLE cycle after release.

## Test plan
- Reset, then a fetch read of addr 0x0010 with mem word 0xA5A5 (WAIT_STATES=2):
  - if_gnt in cycle 0; mem_enable in cycle 3 only; if_done with if_rdata=0xA5A5 in cycle 4; busy in cycles 1-4.
- d_req and if_req raised in the same cycle after reset:
  - Data granted first.
  - Fetch granted in the IDLE cycle after d_done.
  - With both held, grants alternate data/fetch/data.
- Data write of 0x1234 to 0x0020, then a data read of 0x0020:
  - The write shows mem_wr=1 in ACCESS only.
  - The read returns d_rdata=0x1234.
  - if_rdata is unchanged throughout.
- Data read of 0x0021 (misaligned):
  - d_done with err=1 and d_rdata=0x0000 in cycle 1.
  - mem_enable never asserts.
- rst=0 pulse during WAIT of a write:
  - Outputs go to reset values immediately.
  - No mem_wr and no d_done.
  - The memory word at the target address is unchanged.
- WAIT_STATES=0: fetch done in cycle 2, and two back-to-back fetches complete 3 cycles apart.
